keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner for ROWS×COLS active-low keypads on GPIO headers. Drives one row low at a time, synchronises and debounces every key individually, and emits press events as linear key codes through a small FIFO with a valid/ready handshake. Sits between the GPIO pins and the application logic that consumes keypad input.

---
 rtl/keypad_scanner.sv | 223 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix keypad scanner with per-key debounce and a press-event FIFO.
// Optional feature: define KEYPAD_REPEAT_EN to auto-repeat the most recently pressed key.

module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  parameter int KEY_W        = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ROWS-1:0]        row_n,
  input  logic [COLS-1:0]        col_n,
  output logic [KEY_W-1:0]       key_code,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic [ROWS*COLS-1:0]   key_down,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int NK   = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DEBOUNCE + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [DW-1:0]  D_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  D_LATCH = DW'(SCAN_DIV - COLS - 1);
  localparam logic [DW-1:0]  D_PROC0 = DW'(SCAN_DIV - COLS);
  localparam logic [RW-1:0]  R_LAST  = RW'(ROWS - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  if (ROWS < 1 || COLS < 1 || SCAN_DIV < COLS + 4 || DEBOUNCE < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      KEY_W < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter set");
  end

  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    next_row;
  logic [DW-1:0]    dwell;
  logic [COLS-1:0]  col_s1;
  logic [COLS-1:0]  col_s2;
  logic [COLS-1:0]  sample;
  logic [DBW-1:0]   deb_cnt [NK];

  logic             proc_en;
  logic [CLW-1:0]   col_idx;
  logic [KEY_W-1:0] key_idx;
  logic             s_bit;
  logic             cur_down;
  logic [DBW-1:0]   cur_cnt;
  logic             disagree;
  logic             flip;
  logic             press_evt;

  logic             push_req;
  logic [KEY_W-1:0] push_code;
  logic             push;
  logic             pop;
  logic             full;
  logic [KEY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;

  // Row sequencer; row_n is registered so the pins never see decode glitches.
  assign next_row = (row_idx == R_LAST) ? '0 : row_idx + RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      row_idx <= '0;
      row_n   <= ~ROWS'(1);
    end else if (dwell == D_LAST) begin
      dwell   <= '0;
      row_idx <= next_row;
      row_n   <= ~(ROWS'(1) << next_row);
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
      sample <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (dwell == D_LATCH) sample <= ~col_s2;
    end
  end

  // The last COLS cycles of each row dwell walk the columns, one key per cycle.
  assign proc_en   = (dwell >= D_PROC0);
  assign col_idx   = CLW'(dwell - D_PROC0);
  assign key_idx   = KEY_W'(row_idx) * KEY_W'(COLS) + KEY_W'(col_idx);
  assign s_bit     = sample[col_idx];
  assign cur_down  = key_down[key_idx];
  assign cur_cnt   = deb_cnt[key_idx];
  assign disagree  = proc_en && (s_bit != cur_down);
  assign flip      = disagree && (cur_cnt == DB_LAST);
  assign press_evt = flip && s_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_down <= '0;
      for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
    end else if (proc_en) begin
      if (!disagree) begin
        deb_cnt[key_idx] <= '0;
      end else if (flip) begin
        deb_cnt[key_idx]  <= '0;
        key_down[key_idx] <= s_bit;
      end else begin
        deb_cnt[key_idx] <= cur_cnt + DBW'(1);
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat tracker
  //   state     | meaning
  //   REP_IDLE  | no key tracked
  //   REP_DELAY | tracked key held, counting frame ends toward REPEAT_DELAY
  //   REP_RATE  | first repeat sent, counting frame ends toward REPEAT_RATE
  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_RATE} rep_state_t;

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int FW      = $clog2(REP_MAX + 1);
  localparam logic [FW-1:0] F_DELAY = FW'(REPEAT_DELAY - 1);
  localparam logic [FW-1:0] F_RATE  = FW'(REPEAT_RATE - 1);

  rep_state_t       rep_state;
  rep_state_t       rep_next;
  logic [KEY_W-1:0] rep_key;
  logic [FW-1:0]    frm_cnt;
  logic             frame_end;
  logic             rep_release;
  logic             rep_due;
  logic             rep_push;

  assign frame_end   = (dwell == D_LAST) && (row_idx == R_LAST);
  assign rep_release = flip && !s_bit && (key_idx == rep_key);
  assign rep_due     = frame_end && (rep_state != REP_IDLE) &&
                       (frm_cnt == ((rep_state == REP_DELAY) ? F_DELAY : F_RATE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_state <= REP_IDLE;
    else        rep_state <= rep_next;
  end

  always_comb begin
    rep_next = rep_state;
    if (press_evt)        rep_next = REP_DELAY;
    else if (rep_release) rep_next = REP_IDLE;
    else if (rep_due)     rep_next = REP_RATE;
  end

  always_comb begin
    rep_push = 1'b0;
    if (rep_due && !press_evt && !rep_release) rep_push = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_key <= '0;
      frm_cnt <= '0;
    end else if (press_evt) begin
      rep_key <= key_idx;
      frm_cnt <= '0;
    end else if (frame_end && rep_state != REP_IDLE) begin
      frm_cnt <= rep_due ? '0 : frm_cnt + FW'(1);
    end
  end

  assign push_req  = press_evt || rep_push;
  assign push_code = press_evt ? key_idx : rep_key;
`else
  assign push_req  = press_evt;
  assign push_code = key_idx;
`endif

  // Event FIFO; a pop frees the slot in the same cycle, so push+pop on full both land.
  assign key_valid = (count != '0);
  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign push      = push_req && (!full || pop);
  assign key_code  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_code;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CNTW'(1);
      else if (pop && !push) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overflow <= 1'b0;
    else if (push_req && full && !pop) overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner on a 4x4 ideal switch matrix.
// Repeat-specific sequences are built only when KEYPAD_REPEAT_EN is defined.

module tb_keypad_scanner;

  localparam int FRAME = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_down;
  logic        overflow;
  logic        ovf_clr;
  logic [3:0]  pressed [4];

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(16), .DEBOUNCE(3), .FIFO_DEPTH(4),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // ideal switch matrix: a pressed key shorts its column to the driven (low) row
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r]) col_n = col_n & ~pressed[r];
  end

  typedef struct {
    int          row;
    int          col;
    logic [3:0]  code;
    logic [15:0] down;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  // returns on the first negedge of a fresh dwell of row r (dwell count 0)
  task automatic wait_row(input int r);
    logic [3:0] tgt;
    int i;
    tgt = ~(4'b0001 << r);
    i = 0;
    while (row_n == tgt && i < 200) begin @(negedge clk); i++; end
    while (row_n != tgt && i < 200) begin @(negedge clk); i++; end
    if (row_n != tgt) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_row: row_n=%b never reached %b", row_n, tgt);
    end
  endtask

  task automatic pop_expect(input string name, input logic [3:0] code);
    check({name, "_valid"}, key_valid, 1'b1);
    check({name, "_code"}, key_code, code);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

`ifdef KEYPAD_REPEAT_EN
  int         cyc = 0;
  int         ev_time [$];
  logic [3:0] ev_code [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && key_valid && key_ready) begin
      ev_time.push_back(cyc);
      ev_code.push_back(key_code);
    end
  end
`endif

  initial begin
    int t8;
    int t11;
    int n_ev;
    logic [3:0] exp_rows [4];

    vecs[0] = '{1, 2, 4'd6,  16'h0040};
    vecs[1] = '{0, 0, 4'd0,  16'h0001};
    vecs[2] = '{3, 3, 4'd15, 16'h8000};
    vecs[3] = '{2, 1, 4'd9,  16'h0200};
    vecs[4] = '{3, 0, 4'd12, 16'h1000};
    vecs[5] = '{0, 3, 4'd3,  16'h0008};
    exp_rows[0] = 4'b1101;
    exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111;
    exp_rows[3] = 4'b1110;

    rst_n = 1'b0;
    key_ready = 1'b0;
    ovf_clr = 1'b0;
    release_all();
    wait_cycles(3);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 16'h0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_code", key_code, 4'h0);
    rst_n = 1'b1;

    // load one event, then reset mid-scan: the FIFO entry must be discarded
    wait_cycles(20);
    pressed[1] = 4'b0100;
    wait_cycles(5 * FRAME);
    check("pre_reset_valid", key_valid, 1'b1);
    wait_cycles(7);
    rst_n = 1'b0;
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_down", key_down, 16'h0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_code", key_code, 4'h0);
    release_all();
    wait_cycles(3);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 15) check("row_hold15", row_n, 4'b1110);
      if (i % 16 == 0) check("row_step", row_n, exp_rows[i / 16 - 1]);
    end

    // bounce: key 0 seen on exactly two consecutive samples
    wait_row(3);
    pressed[0] = 4'b0001;
    wait_cycles(2 * FRAME);
    check("bounce_down_held", key_down, 16'h0);
    release_all();
    wait_cycles(3 * FRAME);
    check("bounce_down", key_down, 16'h0);
    check("bounce_valid", key_valid, 1'b0);

`ifndef KEYPAD_REPEAT_EN
    for (int i = 0; i < 6; i++) begin
      pressed[vecs[i].row] = 4'b0001 << vecs[i].col;
      wait_cycles(5 * FRAME);
      check("vec_down", key_down, vecs[i].down);
      check("vec_valid", key_valid, 1'b1);
      check("vec_code", key_code, vecs[i].code);
      wait_cycles(FRAME);
      check("vec_hold_code", key_code, vecs[i].code);
      pop_expect("vec_pop", vecs[i].code);
      check("vec_popped", key_valid, 1'b0);
      release_all();
      wait_cycles(5 * FRAME);
      check("vec_rel_down", key_down, 16'h0);
      check("vec_rel_valid", key_valid, 1'b0);
    end

    // same-row pair: col0 then col3 of row 2
    t8 = -1;
    t11 = -1;
    pressed[2] = 4'b1001;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      if (key_down[8] && t8 < 0) t8 = i;
      if (key_down[11] && t11 < 0) t11 = i;
      if (t8 >= 0 && t11 >= 0) break;
    end
    check("pair_seen", (t8 >= 0 && t11 >= 0), 1'b1);
    check("pair_gap", t11 - t8, 3);
    check("pair_down", key_down, 16'h0900);
    pop_expect("pair_first", 4'd8);
    pop_expect("pair_second", 4'd11);
    check("pair_empty", key_valid, 1'b0);
    release_all();
    wait_cycles(5 * FRAME);

    // overflow: keys 0..4 with the consumer stalled
    wait_row(3);
    pressed[0] = 4'hF;
    pressed[1] = 4'h1;
    wait_cycles(6 * FRAME);
    check("ovf_down", key_down, 16'h001F);
    check("ovf_valid", key_valid, 1'b1);
    check("ovf_head", key_code, 4'd0);
    check("ovf_set", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    release_all();
    wait_cycles(5 * FRAME);
    check("ovf_rel_down", key_down, 16'h0);
    check("ovf_rel_head", key_code, 4'd0);

    // key 5 flips on its third sample; pop during that processing cycle (row 1, dwell 13)
    wait_row(3);
    pressed[1] = 4'b0010;
    wait_row(1);
    wait_row(1);
    wait_row(1);
    wait_cycles(13);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("pp_down5", key_down[5], 1'b1);
    check("pp_ovf", overflow, 1'b0);
    pop_expect("pp_1", 4'd1);
    pop_expect("pp_2", 4'd2);
    pop_expect("pp_3", 4'd3);
    pop_expect("pp_5", 4'd5);
    check("pp_empty", key_valid, 1'b0);
    release_all();
    wait_cycles(5 * FRAME);
`else
    key_ready = 1'b1;
    wait_row(3);
    pressed[1] = 4'b0010;
    for (int i = 0; i < 6 * FRAME && ev_time.size() == 0; i++) @(negedge clk);
    check("rep_first_seen", ev_time.size() > 0, 1'b1);
    wait_cycles(9 * FRAME);
    check("rep_count", ev_time.size() >= 4, 1'b1);
    if (ev_time.size() >= 4) begin
      check("rep_gap_delay", ev_time[1] - ev_time[0], 226);
      check("rep_gap_rate1", ev_time[2] - ev_time[1], 128);
      check("rep_gap_rate2", ev_time[3] - ev_time[2], 128);
    end
    for (int i = 0; i < ev_code.size(); i++) check("rep_code", ev_code[i], 4'd5);
    release_all();
    for (int i = 0; i < 6 * FRAME && key_down[5]; i++) @(negedge clk);
    check("rep_released", key_down[5], 1'b0);
    n_ev = ev_time.size();
    wait_cycles(6 * FRAME);
    check("rep_stopped", ev_time.size(), n_ev);
    check("rep_empty", key_valid, 1'b0);
    key_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
